// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - CPU store/load port bundle for the memory-mapped UART transmitter
//
// Purpose : groups the CPU data-port signals that reach mmio_uart_tx.
// Signals :
//   MemWrite    store strobe from the CPU
//   Mem_WrAddr  store/load word address (ALU result)
//   Mem_WrData  store data
//   sel         UART address window hit (driven by the UART)
//   ReadData    STATUS word for loads (driven by the UART)
// Modports: master = CPU side, slave = UART side.

interface mmio_uart_tx_if;
   logic        MemWrite;
   logic [31:0] Mem_WrAddr;
   logic [31:0] Mem_WrData;
   logic        sel;
   logic [31:0] ReadData;

   modport master (
      output MemWrite, Mem_WrAddr, Mem_WrData,
      input  sel, ReadData
   );

   modport slave (
      input  MemWrite, Mem_WrAddr, Mem_WrData,
      output sel, ReadData
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO
//
// Purpose : stores to TXDATA (BASE_ADDR) are queued in a circular FIFO and
//           shifted out LSB first as 8N1 frames; STATUS (BASE_ADDR+4) is
//           returned combinationally so a single-cycle load sees it at once.
// Ports   :
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   bus     CPU data port (slave side): MemWrite, Mem_WrAddr, Mem_WrData in;
//           sel, ReadData out
//   tx      registered serial output, idle high
// STATUS  : [0] full, [1] empty, [2] busy, [3] ovf (sticky), [15:8] count.

module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   mmio_uart_tx_if.slave bus,
   output logic          tx
);

   localparam int unsigned PW          = $clog2(FIFO_DEPTH);
   localparam int unsigned CW          = PW + 1;
   localparam logic [15:0] BC_RELOAD   = 16'(CLK_DIV - 1);
   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [15:0]     bc_q, bc_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            full, empty, pop, push, push_req, ovf_set, ovf_clr;
   logic [7:0]      count_b;
   logic [31:0]     status;
   logic            unused_wrdata;

   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign pop      = (state_q == S_IDLE) && !empty;
   assign push_req = bus.MemWrite && (bus.Mem_WrAddr == BASE_ADDR);
   // A full FIFO still accepts a byte on the edge that pops the head.
   assign push     = push_req && (!full || pop);
   assign ovf_set  = push_req && !push;
   assign ovf_clr  = bus.MemWrite && (bus.Mem_WrAddr == STATUS_ADDR) && bus.Mem_WrData[3];

   assign unused_wrdata = ^bus.Mem_WrData[31:8];

   assign count_b = 8'(count_q);
   assign status  = {16'h0000, count_b, 4'h0, ovf_q, (state_q != S_IDLE), empty, full};

   assign bus.sel      = (bus.Mem_WrAddr[31:3] == BASE_ADDR[31:3]);
   assign bus.ReadData = (bus.Mem_WrAddr == STATUS_ADDR) ? status : 32'h0;
   assign tx           = tx_q;

   // FIFO and overflow bookkeeping
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      ovf_d    = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (ovf_set) ovf_d = 1'b1;   // overflow beats a concurrent clear
   end

   // Serializer next state; tx is derived from the next state so the line
   // changes on the same edge as the state and stays glitch-free.
   always_comb begin
      state_d   = state_q;
      bc_d      = bc_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               shift_d = mem_q[rd_ptr_q];
               bc_d    = BC_RELOAD;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bc_q == 16'd0) begin
               bc_d      = BC_RELOAD;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               bc_d = bc_q - 16'd1;
            end
         end
         S_DATA: begin
            if (bc_q == 16'd0) begin
               bc_d = BC_RELOAD;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               bc_d = bc_q - 16'd1;
            end
         end
         S_STOP: begin
            if (bc_q == 16'd0) state_d = S_IDLE;
            else               bc_d    = bc_q - 16'd1;
         end
         default: state_d = S_IDLE;
      endcase

      tx_d = 1'b1;
      if (state_d == S_START)     tx_d = 1'b0;
      else if (state_d == S_DATA) tx_d = shift_d[0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         bc_q      <= 16'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         tx_q      <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bc_q      <= bc_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   // FIFO storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.Mem_WrData[7:0];
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx

module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam logic [31:0] STAT = 32'h0000_0404;
   localparam int          CD   = 4;
   localparam int          FD   = 8;

   logic clk;
   logic reset;
   logic tx;

   mmio_uart_tx_if bus();

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .tx    (tx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Serial receiver model: samples each bit in its middle (negedge samples)
   logic       rx_active = 1'b0;
   int         rx_cnt    = 0;
   logic [7:0] rx_shift  = 8'h00;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   always @(negedge clk) begin
      if (!reset) begin
         rx_active <= 1'b0;
      end else if (!rx_active) begin
         if (tx == 1'b0) begin
            rx_active <= 1'b1;
            rx_cnt    <= 1;
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if (rx_cnt >= CD + CD/2 && rx_cnt < 9*CD && ((rx_cnt - CD - CD/2) % CD) == 0)
            rx_shift <= {tx, rx_shift[7:1]};
         if (rx_cnt == 9*CD + CD/2) begin
            check("stop_bit", {31'b0, tx}, 32'd1);
            rx_q.push_back(rx_shift);
            rx_active <= 1'b0;
         end
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.MemWrite   = 1'b1;
      bus.Mem_WrAddr = a;
      bus.Mem_WrData = d;
      @(posedge clk);
      #1;
      bus.MemWrite   = 1'b0;
      bus.Mem_WrAddr = STAT;
      bus.Mem_WrData = 32'h0;
   endtask

   task automatic expect_status(input string name, input logic [31:0] exp);
      @(negedge clk);
      check(name, bus.ReadData, exp);
   endtask

   task automatic drain_compare(input string name, input int budget);
      int n;
      n = 0;
      while (rx_q.size() < exp_q.size() && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < rx_q.size()) check($sformatf("%s_byte%0d", name, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
      end
      rx_q.delete();
      exp_q.delete();
   endtask

   function automatic logic exp_bit(input int i, input logic [7:0] b);
      if (i < CD)     return 1'b0;
      if (i < 9 * CD) return b[(i - CD) / CD];
      return 1'b1;
   endfunction

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic        exp_sel;
      logic [31:0] exp_rd;
      logic [31:0] exp_stat;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int lows;
      logic [7:0] b;

      vecs[0] = '{1'b0, 32'h0000_0400, 32'h0,  1'b1, 32'h0, 32'h2};
      vecs[1] = '{1'b0, 32'h0000_0404, 32'h0,  1'b1, 32'h2, 32'h2};
      vecs[2] = '{1'b0, 32'h0000_0408, 32'h0,  1'b0, 32'h0, 32'h2};
      vecs[3] = '{1'b0, 32'h0000_0407, 32'h0,  1'b1, 32'h0, 32'h2};
      vecs[4] = '{1'b0, 32'h0000_03FC, 32'h0,  1'b0, 32'h0, 32'h2};
      vecs[5] = '{1'b1, 32'h0000_0408, 32'h41, 1'b0, 32'h0, 32'h2};
      vecs[6] = '{1'b1, 32'h0000_03FC, 32'h41, 1'b0, 32'h0, 32'h2};
      vecs[7] = '{1'b1, 32'h0000_1400, 32'h41, 1'b0, 32'h0, 32'h2};
      vecs[8] = '{1'b1, 32'h0000_0404, 32'h8,  1'b1, 32'h2, 32'h2};
      vecs[9] = '{1'b0, 32'h8000_0404, 32'h0,  1'b0, 32'h0, 32'h2};

      reset          = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.Mem_WrAddr = STAT;
      bus.Mem_WrData = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_tx", {31'b0, tx}, 32'd1);
      check("reset_status", bus.ReadData, 32'h2);
      reset = 1'b1;
      expect_status("post_reset_status", 32'h2);

      // Address decode, STATUS reads and ignored writes
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.MemWrite   = vecs[i].we;
         bus.Mem_WrAddr = vecs[i].addr;
         bus.Mem_WrData = vecs[i].data;
         #1;
         check($sformatf("vec%0d_sel", i), {31'b0, bus.sel}, {31'b0, vecs[i].exp_sel});
         check($sformatf("vec%0d_rd", i), bus.ReadData, vecs[i].exp_rd);
         @(posedge clk);
         #1;
         bus.MemWrite   = 1'b0;
         bus.Mem_WrAddr = STAT;
         bus.Mem_WrData = 32'h0;
         #1;
         check($sformatf("vec%0d_stat", i), bus.ReadData, vecs[i].exp_stat);
      end
      check("ignored_writes_tx", {31'b0, tx}, 32'd1);

      // Single frame 0x55, bit-exact waveform
      bus_write(BASE, 32'hFFFF_FF55);
      exp_q.push_back(8'h55);
      expect_status("push_status", 32'h0000_0100);
      for (int i = 0; i < 10 * CD; i++) begin
         @(negedge clk);
         check($sformatf("f55_tx%0d", i), {31'b0, tx}, {31'b0, exp_bit(i, 8'h55)});
         check($sformatf("f55_busy%0d", i), {31'b0, bus.ReadData[2]}, 32'd1);
         if (i == 0) check("f55_after_pop", bus.ReadData, 32'h6);
      end
      @(negedge clk);
      check("f55_idle_status", bus.ReadData, 32'h2);
      check("f55_idle_tx", {31'b0, tx}, 32'd1);
      drain_compare("f55_rx", 10);

      // Overflow: 9 back-to-back writes fill the FIFO behind one popped byte
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         bus.MemWrite   = 1'b1;
         bus.Mem_WrAddr = BASE;
         bus.Mem_WrData = 32'hA0 + 32'(i);
         exp_q.push_back(8'hA0 + 8'(i));
         @(posedge clk);
         #1;
      end
      bus.MemWrite   = 1'b0;
      bus.Mem_WrAddr = STAT;
      expect_status("nine_writes_status", 32'h0000_0805);
      bus_write(BASE, 32'hA9);
      expect_status("tenth_write_ovf", 32'h0000_080D);
      bus_write(STAT, 32'h0);
      expect_status("ovf_clear_bit0", 32'h0000_080D);
      bus_write(STAT, 32'h8);
      expect_status("ovf_clear", 32'h0000_0805);

      // Push exactly on the pop edge of a full FIFO
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.ReadData[2] !== 1'b0 && n < 200);
      check("wait_idle_found", {31'b0, bus.ReadData[2]}, 32'd0);
      check("full_at_pop_edge", {31'b0, bus.ReadData[0]}, 32'd1);
      bus.MemWrite   = 1'b1;
      bus.Mem_WrAddr = BASE;
      bus.Mem_WrData = 32'hB9;
      exp_q.push_back(8'hB9);
      @(posedge clk);
      #1;
      bus.MemWrite   = 1'b0;
      bus.Mem_WrAddr = STAT;
      bus.Mem_WrData = 32'h0;
      expect_status("push_on_pop_status", 32'h0000_0805);
      drain_compare("ovf_rx", 1000);
      expect_status("drained_status", 32'h2);

      // Reset in the middle of a DATA bit
      bus_write(BASE, 32'h00);
      bus_write(BASE, 32'h3C);
      repeat (8) @(negedge clk);
      check("pre_reset_tx", {31'b0, tx}, 32'd0);
      #2;
      reset = 1'b0;
      #1;
      check("reset_mid_tx", {31'b0, tx}, 32'd1);
      check("reset_mid_status", bus.ReadData, 32'h0000_0002);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx == 1'b0) lows++;
      end
      check("no_residual_low", lows, 0);
      check("no_residual_rx", rx_q.size(), 0);
      check("after_reset_status", bus.ReadData, 32'h2);
      rx_q.delete();

      // Three FIFO depths of traffic to exercise pointer wrap
      for (int i = 0; i < 3 * FD; i++) begin
         b = 8'(i * 37 + 11);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (bus.ReadData[0] !== 1'b0 && n < 200);
         bus.MemWrite   = 1'b1;
         bus.Mem_WrAddr = BASE;
         bus.Mem_WrData = {24'h0, b};
         exp_q.push_back(b);
         @(posedge clk);
         #1;
         bus.MemWrite   = 1'b0;
         bus.Mem_WrAddr = STAT;
         bus.Mem_WrData = 32'h0;
      end
      drain_compare("wrap_rx", 3000);
      expect_status("wrap_final_status", 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
